dewhiten_deframer: RTL
======================

// Module: dewhiten_deframer
// PURPOSE
//  Next-generation PHY receive deframer: packs a serial/narrow bit stream into bytes, parses a
//  2-byte PHR (length, FCS type, data-whitening flag), de-whitens PSDU+FCS with PN9 and tags
//  each output byte as PHR/PSDU/FCS. Sits between demodulator bit slicer and MAC byte interface.
//  Adds over prior block: IN_W-bit beats, valid gaps (stall), sof framing, DW/FCS-type honoured, length check.
// PARAMETERS
//  IN_W        1      bits per input beat; legal 1,2,4,8; data_in[0] is earliest bit
//  PN_SEED     9'h1FF PN9 seed loaded at every frame start
//  PHR_WHITEN  0      1 = legacy mode: PHR bytes also de-whitened, LFSR runs from PHR byte0
//  LEN_W       11     frame-length field width (max 16)
//  MAX_LEN     2047   largest accepted length L (bytes, PSDU+FCS)
// PORTS
//  clk            in   1      clock, all logic on posedge
//  rst_n          in   1      asynchronous reset, active low
//  data_in        in   IN_W   input bits, LSB first on air
//  data_in_valid  in   1      beat qualifier; low = stall, all state held
//  sof            in   1      start of frame, sampled only with data_in_valid; marks first beat
//  data_out       out  8      byte out (0 when data_out_valid==0)
//  data_out_valid out  2      0 none, 1 PHR, 2 PSDU, 3 FCS
//  fcs_end        out  1      pulse with last FCS byte
//  frame_len      out  LEN_W  L of current frame, valid from 2nd PHR byte until next sof
//  len_err        out  1      pulse: L rejected
//  abort          out  1      pulse: sof arrived while frame in progress
//  busy           out  1      high from sof until fcs_end/len_err/abort
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, LFSR=PN_SEED, counters 0. Reset mid-frame discards frame.
//  - Byte assembly: BEATS=8/IN_W beats per byte, bits shifted in LSB first; beat counter log2(BEATS).
//  - Latency: byte outputs registered, valid exactly 1 cycle after the beat completing the byte;
//    outputs are single-cycle pulses, no backpressure.
//  - States: IDLE -> (valid&sof) PHR0 -> PHR1 -> PSDU -> FCS -> IDLE; DROP entered on len_err.
//    IDLE/DROP ignore beats without sof. valid&sof in any state restarts at PHR0 (beat = bit 0 of
//    new frame); abort pulses if state was PHR0..FCS with ≥1 beat consumed. sof wins over all events.
//  - PHR: byte0 b4=FCS type (1:2-byte FCS, 0:4-byte), b3=DW; L={byte0,byte1}[LEN_W-1:0].
//    PHR bytes output raw (code 1) unless PHR_WHITEN=1.
//  - Length check at PHR1 completion: L<=FCS_LEN or L>MAX_LEN -> len_err pulse (same cycle as
//    PHR1 byte out), -> DROP. Else PSDU count=L-FCS_LEN, then FCS count=FCS_LEN; byte counter LEN_W bits.
//  - Whitening: PN9 x^9+x^5+1; per bit w=lfsr[0], lfsr<={lfsr[0]^lfsr[5],lfsr[8:1]}; IN_W steps/beat.
//    LFSR reseeded at sof; advances only on consumed bits of whitened bytes. out=byte^w when DW=1
//    (or PHR_WHITEN=1 for PHR); DW=0 -> raw. First two PN9 bytes from 1FF: 0xFF,0xE1.
//  - fcs_end with last FCS byte; same cycle state->IDLE, busy falls next cycle.
// STRUCTURE
//  - dewhiten_pkg: out-type codes (NONE/PHR/PSDU/FCS), state enum, PN9 tap indices, PHR bit
//    positions (FCS_TYPE_BIT=4, DW_BIT=3), FCS_LEN_2/FCS_LEN_4 constants.
//  - Sub-module pn9_lfsr #(STEP=IN_W): load seed, hold, or advance STEP bits; outputs STEP w-bits.
// TESTING
//  - IN_W=1, PHR 0x18,0x04 (DW=1,2B FCS,L=4), body 0xFF,0xE1,0x1D,0x9A -> bytes 18,04,00,00,00,00
//    codes 1,1,2,2,3,3; fcs_end with 6th; frame_len=4.
//  - PHR 0x10,0x02 (L=2=FCS_LEN) -> codes 1,1 then len_err pulse; further beats give no output.
//  - IN_W=8, test 1 stream with random valid gaps -> identical bytes, each 1 cycle after its beat.
//  - DW=0 PHR 0x00,0x06 (4B FCS,L=6) body 01..06 -> raw 01,02 code 2, 03..06 code 3.
//  - sof mid-PSDU then test-1 frame -> abort pulse, new frame output correct (LFSR reseeded).
//  - rst_n low mid-FCS -> all outputs 0 at once; next sof frame decodes as test 1.

Source files
------------

// File: rtl/dewhiten_pkg.sv
// Shared types and constants for the PHY receive deframer.
// No logic, no latency, no flow control.
package dewhiten_pkg;

    typedef enum logic [1:0] {
        OUT_NONE = 2'd0,
        OUT_PHR  = 2'd1,
        OUT_PSDU = 2'd2,
        OUT_FCS  = 2'd3
    } out_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PHR0,
        ST_PHR1,
        ST_PSDU,
        ST_FCS,
        ST_DROP
    } state_t;

    localparam int PN9_TAP_A    = 0;
    localparam int PN9_TAP_B    = 5;
    localparam int FCS_TYPE_BIT = 4;
    localparam int DW_BIT       = 3;
    localparam int FCS_LEN_2    = 2;
    localparam int FCS_LEN_4    = 4;

    // One PN9 (x^9+x^5+1) step: output bit is s[0], feedback enters at the top.
    function automatic logic [8:0] pn9_step(input logic [8:0] s);
        return {s[PN9_TAP_A] ^ s[PN9_TAP_B], s[8:1]};
    endfunction

endpackage

// File: rtl/pn9_lfsr.sv
// PN9 whitening sequence generator: load seed, hold, or advance STEP bits per cycle.
// w is combinational from the (possibly just-loaded) state; state updates on the clock edge.
module pn9_lfsr
    import dewhiten_pkg::*;
#(
    parameter int         STEP = 1,
    parameter logic [8:0] SEED = 9'h1FF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            adv,
    output logic [STEP-1:0] w
);

    logic [8:0] lfsr_q, lfsr_d, base, walk;

    always_comb begin
        base = load ? SEED : lfsr_q;
        walk = base;
        w    = '0;
        for (int i = 0; i < STEP; i++) begin
            w[i] = walk[0];
            walk = pn9_step(walk);
        end
        lfsr_d = adv ? walk : base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/dewhiten_deframer.sv
// PHY rx deframer: packs IN_W-bit beats to bytes, parses PHR, de-whitens PSDU+FCS, tags bytes.
// Byte outputs registered one cycle after the completing beat; no backpressure, valid-low stalls.
module dewhiten_deframer
    import dewhiten_pkg::*;
#(
    parameter int         IN_W       = 1,
    parameter logic [8:0] PN_SEED    = 9'h1FF,
    parameter bit         PHR_WHITEN = 1'b0,
    parameter int         LEN_W      = 11,
    parameter int         MAX_LEN    = 2047
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  data_in,
    input  logic             data_in_valid,
    input  logic             sof,
    output logic [7:0]       data_out,
    output logic [1:0]       data_out_valid,
    output logic             fcs_end,
    output logic [LEN_W-1:0] frame_len,
    output logic             len_err,
    output logic             abort,
    output logic             busy
);

    localparam int               BEATS     = 8 / IN_W;
    localparam int               CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0]    LAST_BEAT = CW'(BEATS - 1);
    localparam logic [LEN_W:0]   MAX_L     = (LEN_W+1)'(MAX_LEN);

    state_t           state_q, state_d, cur;
    logic [CW-1:0]    beat_q, beat_d, beat_cur;
    logic [7:0]       sr_q, sr_d, wsr_q, wsr_d, phr0_q, phr0_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, flen_q, flen_d, len_v, fcs_len;
    logic             dw_q, dw_d, fcs2_q, fcs2_d;
    logic [7:0]       out_q, out_d, byte_raw, wbyte, dbyte;
    out_t             code_q, code_d;
    logic             fcs_end_q, fcs_end_d, len_err_q, len_err_d;
    logic             abort_q, abort_d, busy_q, busy_d;
    logic             start, active, take, whiten, adv, byte_done;
    logic [IN_W-1:0]  wbits, wsel;

    // A sof beat is bit 0 of a new frame regardless of what was in flight.
    assign start  = data_in_valid & sof;
    assign active = state_q inside {ST_PHR0, ST_PHR1, ST_PSDU, ST_FCS};
    assign take   = data_in_valid & (sof | active);
    assign cur    = start ? ST_PHR0 : state_q;
    assign whiten = (cur == ST_PHR0 || cur == ST_PHR1) ? PHR_WHITEN : dw_q;
    assign adv    = take & whiten;

    pn9_lfsr #(.STEP(IN_W), .SEED(PN_SEED)) u_pn9 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start),
        .adv   (adv),
        .w     (wbits)
    );

    always_comb begin
        beat_cur  = start ? '0 : beat_q;
        wsel      = whiten ? wbits : '0;
        byte_raw  = 8'({data_in, sr_q} >> IN_W);
        wbyte     = 8'({wsel, wsr_q} >> IN_W);
        dbyte     = byte_raw ^ wbyte;
        byte_done = take && (beat_cur == LAST_BEAT);
        len_v     = LEN_W'({phr0_q, dbyte});
        fcs_len   = fcs2_q ? LEN_W'(FCS_LEN_2) : LEN_W'(FCS_LEN_4);

        state_d   = state_q;
        beat_d    = beat_q;
        sr_d      = sr_q;
        wsr_d     = wsr_q;
        cnt_d     = cnt_q;
        phr0_d    = phr0_q;
        dw_d      = dw_q;
        fcs2_d    = fcs2_q;
        flen_d    = flen_q;
        out_d     = '0;
        code_d    = OUT_NONE;
        fcs_end_d = 1'b0;
        len_err_d = 1'b0;
        abort_d   = start & active;
        busy_d    = start | active;

        if (take) begin
            sr_d    = byte_raw;
            wsr_d   = wbyte;
            beat_d  = byte_done ? '0 : beat_cur + CW'(1);
            state_d = cur;
        end

        if (byte_done) begin
            out_d = dbyte;
            case (cur)
                ST_PHR0: begin
                    code_d  = OUT_PHR;
                    phr0_d  = dbyte;
                    dw_d    = dbyte[DW_BIT];
                    fcs2_d  = dbyte[FCS_TYPE_BIT];
                    state_d = ST_PHR1;
                end
                ST_PHR1: begin
                    code_d = OUT_PHR;
                    flen_d = len_v;
                    // The frame must carry at least one PSDU byte beyond its FCS.
                    if (len_v <= fcs_len || {1'b0, len_v} > MAX_L) begin
                        len_err_d = 1'b1;
                        state_d   = ST_DROP;
                    end else begin
                        cnt_d   = len_v - fcs_len;
                        state_d = ST_PSDU;
                    end
                end
                ST_PSDU: begin
                    code_d = OUT_PSDU;
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        cnt_d   = fcs_len;
                        state_d = ST_FCS;
                    end
                end
                ST_FCS: begin
                    code_d = OUT_FCS;
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        fcs_end_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            sr_q      <= '0;
            wsr_q     <= '0;
            cnt_q     <= '0;
            phr0_q    <= '0;
            dw_q      <= 1'b0;
            fcs2_q    <= 1'b0;
            flen_q    <= '0;
            out_q     <= '0;
            code_q    <= OUT_NONE;
            fcs_end_q <= 1'b0;
            len_err_q <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            sr_q      <= sr_d;
            wsr_q     <= wsr_d;
            cnt_q     <= cnt_d;
            phr0_q    <= phr0_d;
            dw_q      <= dw_d;
            fcs2_q    <= fcs2_d;
            flen_q    <= flen_d;
            out_q     <= out_d;
            code_q    <= code_d;
            fcs_end_q <= fcs_end_d;
            len_err_q <= len_err_d;
            abort_q   <= abort_d;
            busy_q    <= busy_d;
        end
    end

    assign data_out       = out_q;
    assign data_out_valid = code_q;
    assign fcs_end        = fcs_end_q;
    assign frame_len      = flen_q;
    assign len_err        = len_err_q;
    assign abort          = abort_q;
    assign busy           = busy_q;

endmodule
